// File: rtl/display_pkg.sv
// Shared codes, segment patterns and FSM states for the multiplexed display path.
package display_pkg;

   localparam logic [3:0] CODE_DASH  = 4'd14;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   localparam logic [0:6] SEG_DASH  = 7'b1111110;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

endpackage

// File: rtl/display_scan_driver_seg_decoder.sv
// Combinational 4-bit digit code to active-low segments, bit order [0:6] = a..g.
module seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] code,
   output logic [0:6] seg
);

   always_comb begin
      case (code)
         4'd0:       seg = 7'b0000001;
         4'd1:       seg = 7'b1001111;
         4'd2:       seg = 7'b0010010;
         4'd3:       seg = 7'b0000110;
         4'd4:       seg = 7'b1001100;
         4'd5:       seg = 7'b0100100;
         4'd6:       seg = 7'b0100000;
         4'd7:       seg = 7'b0001101;
         4'd8:       seg = 7'b0000000;
         4'd9:       seg = 7'b0000100;
         CODE_BLANK: seg = SEG_BLANK;
         default:    seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/display_scan_driver.sv
// Sequential binary-to-BCD conversion with blanking/sign/overflow, multiplexed onto one segment bus.
// Optional decimal point: define DISPLAY_DP_EN to add dp_pos / dp.
module display_scan_driver
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int WIDTH    = 14,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  value,
   input  logic              negative,
   input  logic              load,
   input  logic              blank,
`ifdef DISPLAY_DP_EN
   input  logic [$clog2(DIGITS)-1:0] dp_pos,
   output logic              dp,
`endif
   output logic [0:6]        hex,
   output logic [DIGITS-1:0] digit_en,
   output logic              busy,
   output logic              overflow
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = 4 * DIGITS;

   state_t          state;
   logic [WIDTH-1:0] bin;
   logic [BW-1:0]   bcd;
   logic            lost;
   logic            neg_cap;
   logic [CW-1:0]   cnt;
   logic [3:0]      disp [DIGITS];
   logic [SW-1:0]   scnt;
   logic [IW-1:0]   sidx;

   logic [BW-1:0]   adj;
   logic [BW-1:0]   bcd_step;
   logic            carry_out;
   int unsigned     msd;
   logic            is_zero;
   logic            ovf_next;
   logic [3:0]      disp_next [DIGITS];
   logic [DIGITS-1:0] en_next;
   logic [0:6]      seg_w;

`ifdef DISPLAY_DP_EN
   logic [IW-1:0]   dp_cap;
   logic [IW-1:0]   dp_com;
`endif

   // A bit carried out of the top nibble means value >= 10^DIGITS; it is kept sticky in 'lost'.
   always_comb begin
      adj = bcd;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      {carry_out, bcd_step} = {adj, bin[WIDTH-1]};
   end

   always_comb begin
      msd = 0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      end
      is_zero  = (bcd == '0) && !lost;
      ovf_next = lost || (neg_cap && !is_zero && (bcd[BW-1 -: 4] != 4'd0));
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (ovf_next)
            disp_next[i] = CODE_DASH;
         else if (i > msd)
            disp_next[i] = (neg_cap && !is_zero && (i == msd + 1)) ? CODE_DASH : CODE_BLANK;
         else
            disp_next[i] = bcd[4*i +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bin      <= '0;
         bcd      <= '0;
         lost     <= 1'b0;
         neg_cap  <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
         for (int unsigned i = 0; i < DIGITS; i++) disp[i] <= CODE_BLANK;
`ifdef DISPLAY_DP_EN
         dp_cap   <= '0;
         dp_com   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  bin     <= value;
                  neg_cap <= negative;
                  bcd     <= '0;
                  lost    <= 1'b0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
`ifdef DISPLAY_DP_EN
                  dp_cap  <= dp_pos;
`endif
               end
            end
            SHIFT: begin
               bcd  <= bcd_step;
               bin  <= bin << 1;
               lost <= lost | carry_out;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= COMMIT;
            end
            COMMIT: begin
               for (int unsigned i = 0; i < DIGITS; i++) disp[i] <= disp_next[i];
               overflow <= ovf_next;
               busy     <= 1'b0;
               state    <= IDLE;
`ifdef DISPLAY_DP_EN
               dp_com   <= dp_cap;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      en_next = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!blank && (IW'(i) == sidx)) en_next[i] = 1'b0;
      end
   end

   seg_decoder u_dec (
      .code (disp[sidx]),
      .seg  (seg_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt     <= '0;
         sidx     <= '0;
         hex      <= SEG_BLANK;
         digit_en <= '1;
`ifdef DISPLAY_DP_EN
         dp       <= 1'b1;
`endif
      end else begin
         if (scnt == SW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            sidx <= (sidx == IW'(DIGITS - 1)) ? '0 : sidx + IW'(1);
         end else begin
            scnt <= scnt + SW'(1);
         end
         hex      <= seg_w;
         digit_en <= en_next;
`ifdef DISPLAY_DP_EN
         dp       <= !((sidx == dp_com) && !blank && !overflow);
`endif
      end
   end

endmodule
